// File: rtl/sd_adc_decimator.sv
// First-order delta-sigma ADC receive path: comparator synchroniser, feedback bit,
// sinc2 CIC decimator with saturating scaler and a valid/ready output register.
module sd_adc_decimator #(
    parameter int width      = 16,
    parameter int decim_log2 = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    output logic             bit_fb,
    output logic [width-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int W     = 2 * decim_log2 + 1;
    localparam int SHIFT = 2 * decim_log2 - width;

    localparam logic [decim_log2-1:0] CNT_MAX = '1;
    localparam logic [decim_log2-1:0] CNT_ONE = {{(decim_log2-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]          SAT_MAX = {1'b0, {(W-1){1'b1}}};

    typedef logic [width-1:0] sample_t;

    // Registered state and next-state values
    logic                  sync0_q, sync1_q;
    logic [W-1:0]          i1_q, i1_d;
    logic [W-1:0]          i2_q, i2_d;
    logic [decim_log2-1:0] cnt_q, cnt_d;
    logic [W-1:0]          i2_dly_q, i2_dly_d;
    logic [W-1:0]          c1_dly_q, c1_dly_d;
    logic [W-1:0]          c2_q, c2_d;
    logic                  comb_done_q, comb_done_d;
    logic [1:0]            warm_q, warm_d;
    sample_t               smp_q, smp_d;
    logic                  smp_vld_q, smp_vld_d;
    sample_t               dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overrun_q, overrun_d;

    // Combinational helpers
    logic                  bit_s;
    logic                  strobe_s;
    logic [W-1:0]          c1_new_s;
    logic [W-1:0]          c2_new_s;
    logic [W-1:0]          sat_s;
    sample_t               scaled_s;
    logic                  accept_s;
    logic                  ovr_set_s;

    assign bit_s = sync1_q;

    // Next-state logic for integrators, comb stage, warm-up, scaler and output handshake
    always_comb begin
        i1_d         = i1_q + {{(W-1){1'b0}}, bit_s};
        i2_d         = i2_q + i1_q;
        cnt_d        = cnt_q + CNT_ONE;
        strobe_s     = (cnt_q == CNT_MAX);

        // Both comb differences resolve in the same edge: c2 uses the fresh c1.
        c1_new_s     = i2_q - i2_dly_q;
        c2_new_s     = c1_new_s - c1_dly_q;
        i2_dly_d     = i2_dly_q;
        c1_dly_d     = c1_dly_q;
        c2_d         = c2_q;
        comb_done_d  = strobe_s;
        if (strobe_s) begin
            i2_dly_d = i2_q;
            c1_dly_d = c1_new_s;
            c2_d     = c2_new_s;
        end else begin
            i2_dly_d = i2_dly_q;
            c1_dly_d = c1_dly_q;
            c2_d     = c2_q;
        end

        // Full-scale input gives exactly R^2, which must clamp rather than wrap.
        if (c2_q > SAT_MAX) begin
            sat_s = SAT_MAX;
        end else begin
            sat_s = c2_q;
        end
        scaled_s = sample_t'(sat_s >> SHIFT);

        // The first two comb results still carry start-up transients.
        accept_s = comb_done_q && (warm_q >= 2'd2);
        warm_d   = warm_q;
        if (comb_done_q && (warm_q != 2'd3)) begin
            warm_d = warm_q + 2'd1;
        end else begin
            warm_d = warm_q;
        end

        smp_vld_d = accept_s;
        if (accept_s) begin
            smp_d = scaled_s;
        end else begin
            smp_d = smp_q;
        end

        ovr_set_s    = smp_vld_q && dout_valid_q && !dout_ready;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (smp_vld_q) begin
            dout_d       = smp_q;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end

        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q      <= 1'b0;
            sync1_q      <= 1'b0;
            i1_q         <= '0;
            i2_q         <= '0;
            cnt_q        <= '0;
            i2_dly_q     <= '0;
            c1_dly_q     <= '0;
            c2_q         <= '0;
            comb_done_q  <= 1'b0;
            warm_q       <= 2'd0;
            smp_q        <= '0;
            smp_vld_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync0_q      <= bit_in;
            sync1_q      <= sync0_q;
            i1_q         <= i1_d;
            i2_q         <= i2_d;
            cnt_q        <= cnt_d;
            i2_dly_q     <= i2_dly_d;
            c1_dly_q     <= c1_dly_d;
            c2_q         <= c2_d;
            comb_done_q  <= comb_done_d;
            warm_q       <= warm_d;
            smp_q        <= smp_d;
            smp_vld_q    <= smp_vld_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bit_fb     = sync1_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;

endmodule
